arb_prio: RTL and testbench

- Registered N-way request arbiter, the DUT behind the arbiter interface's DUT modport.
- Samples a request vector every clock and drives a one-hot grant vector one cycle later.
- Default mode is fixed priority, with requester 0 highest.
- Optional round-robin mode for fairness. Requesters are the testbench or upstream masters.

---
 rtl/arb_prio_if.sv | 31 +++
 rtl/arb_prio.sv | 83 ++++++++
 tb/tb_arb_prio.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/arb_prio_if.sv
`default_nettype none
// =============================================================================
// Module   : arb_if
// Brief    : Request/grant bundle between requesters and the arb_prio arbiter.
// Revision : 1.0
// =============================================================================
interface arb_if #(
    parameter int N_REQ = 2
);
    localparam int IDX_W = $clog2(N_REQ);

    logic [N_REQ-1:0] request;
    logic [N_REQ-1:0] grant;
    logic             grant_valid;
    logic [IDX_W-1:0] grant_idx;

    modport master (
        output request,
        input  grant,
        input  grant_valid,
        input  grant_idx
    );

    modport slave (
        input  request,
        output grant,
        output grant_valid,
        output grant_idx
    );
endinterface
`default_nettype wire

// File: rtl/arb_prio.sv
`default_nettype none
// =============================================================================
// Module   : arb_prio
// Brief    : Registered N-way arbiter, fixed priority or rotating round robin.
// Revision : 1.0
// =============================================================================
module arb_prio #(
    parameter int N_REQ       = 2,
    parameter int ROUND_ROBIN = 0
) (
    input  logic clk,
    input  logic reset_n,
    arb_if.slave bus
);
    localparam int               IDX_W   = $clog2(N_REQ);
    localparam logic [IDX_W:0]   c_n_req = (IDX_W+1)'(N_REQ);
    localparam logic [IDX_W-1:0] c_last  = IDX_W'(N_REQ - 1);
    localparam logic [N_REQ-1:0] c_one   = N_REQ'(1);

    logic [N_REQ-1:0] r_grant;
    logic             r_grant_valid;
    logic [IDX_W-1:0] r_grant_idx;
    logic [IDX_W-1:0] r_rr_ptr;

    logic [IDX_W-1:0] w_base;
    logic [IDX_W-1:0] w_win;
    logic [IDX_W:0]   w_cand;
    logic             w_found;

    // Fixed priority is round robin with the search origin pinned at 0.
    assign w_base = (ROUND_ROBIN != 0) ? r_rr_ptr : '0;

    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_cand  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            w_cand = {1'b0, w_base} + (IDX_W+1)'(k);
            if (w_cand >= c_n_req) begin
                w_cand = w_cand - c_n_req;
            end
            if (!w_found && bus.request[w_cand[IDX_W-1:0]]) begin
                w_found = 1'b1;
                w_win   = w_cand[IDX_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_grant       <= '0;
            r_grant_valid <= 1'b0;
            r_grant_idx   <= '0;
        end else begin
            r_grant       <= w_found ? (c_one << w_win) : '0;
            r_grant_valid <= w_found;
            r_grant_idx   <= w_win;
        end
    end

    generate
        if (ROUND_ROBIN != 0) begin : g_rr
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_rr_ptr <= '0;
                end else if (w_found) begin
                    r_rr_ptr <= (w_win == c_last) ? '0 : w_win + IDX_W'(1);
                end
            end
        end else begin : g_fixed
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_rr_ptr <= '0;
                end
            end
        end
    endgenerate

    assign bus.grant       = r_grant;
    assign bus.grant_valid = r_grant_valid;
    assign bus.grant_idx   = r_grant_idx;
endmodule
`default_nettype wire

// File: tb/tb_arb_prio.sv
`default_nettype none
`timescale 1ns/1ps
// =============================================================================
// Module   : tb_arb_prio
// Brief    : Self-checking bench: vector tables, reset corners, random stream.
// Revision : 1.0
// =============================================================================
module tb_arb_prio;
    logic clk = 1'b0;
    logic reset_n;

    always #5 clk = ~clk;

    arb_if #(.N_REQ(2)) if2  ();
    arb_if #(.N_REQ(4)) if4r ();
    arb_if #(.N_REQ(4)) if4f ();

    arb_prio u_fp2 (.clk(clk), .reset_n(reset_n), .bus(if2));
    arb_prio #(.N_REQ(4), .ROUND_ROBIN(1)) u_rr4 (.clk(clk), .reset_n(reset_n), .bus(if4r));
    arb_prio #(.N_REQ(4), .ROUND_ROBIN(0)) u_fp4 (.clk(clk), .reset_n(reset_n), .bus(if4f));

    typedef struct {
        logic [3:0] gnt;
        logic       valid;
        logic [1:0] idx;
    } exp_t;

    typedef struct {
        bit         rst_first;
        logic [3:0] req;
        logic [3:0] gnt;
        logic [1:0] idx;
    } vec_t;

    exp_t q2[$];
    exp_t qr[$];
    exp_t qf[$];

    int checks   = 0;
    int failures = 0;
    int m_ptr    = 0;

    vec_t fp2_tab[7];
    vec_t rr4_tab[10];

    function automatic logic [7:0] pack(logic [3:0] g, logic v, logic [1:0] i);
        return {1'b0, g, v, i};
    endfunction

    task automatic check(string name, logic [7:0] act, logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic bit inv_ok(logic [3:0] g, logic v, logic [1:0] idx);
        int n = $countones(g);
        if (n > 1) return 1'b0;
        if (v !== (n == 1)) return 1'b0;
        if (n == 1 && g !== (4'b0001 << idx)) return 1'b0;
        if (n == 0 && idx !== 2'd0) return 1'b0;
        return 1'b1;
    endfunction

    // Lowest set bit isolated arithmetically, index recovered by log2.
    function automatic exp_t fp_model(logic [3:0] req, int n);
        exp_t       e;
        logic [3:0] m;
        logic [3:0] low;
        m       = (n == 2) ? (req & 4'b0011) : req;
        low     = m & (~m + 4'd1);
        e.gnt   = low;
        e.valid = (low != 4'd0);
        e.idx   = 2'($clog2(low));
        return e;
    endfunction

    function automatic exp_t rr_model(logic [3:0] req);
        exp_t e;
        e.gnt   = 4'd0;
        e.valid = 1'b0;
        e.idx   = 2'd0;
        for (int k = 0; k < 4; k++) begin
            int j;
            j = (m_ptr + k) % 4;
            if (req[j]) begin
                e.gnt   = 4'b0001 << j;
                e.valid = 1'b1;
                e.idx   = 2'(j);
                m_ptr   = (j + 1) % 4;
                return e;
            end
        end
        return e;
    endfunction

    task automatic tick(string tag);
        exp_t e;
        @(posedge clk);
        #1;
        if (q2.size() > 0) begin
            e = q2.pop_front();
            check({tag, "/fp2"}, pack({2'b00, if2.grant}, if2.grant_valid, {1'b0, if2.grant_idx}),
                  pack(e.gnt, e.valid, e.idx));
        end
        if (qr.size() > 0) begin
            e = qr.pop_front();
            check({tag, "/rr4"}, pack(if4r.grant, if4r.grant_valid, if4r.grant_idx),
                  pack(e.gnt, e.valid, e.idx));
        end
        if (qf.size() > 0) begin
            e = qf.pop_front();
            check({tag, "/fp4"}, pack(if4f.grant, if4f.grant_valid, if4f.grant_idx),
                  pack(e.gnt, e.valid, e.idx));
        end
        check({tag, "/inv_fp2"}, {7'd0, inv_ok({2'b00, if2.grant}, if2.grant_valid, {1'b0, if2.grant_idx})}, 8'd1);
        check({tag, "/inv_rr4"}, {7'd0, inv_ok(if4r.grant, if4r.grant_valid, if4r.grant_idx)}, 8'd1);
        check({tag, "/inv_fp4"}, {7'd0, inv_ok(if4f.grant, if4f.grant_valid, if4f.grant_idx)}, 8'd1);
    endtask

    task automatic do_reset();
        reset_n      = 1'b0;
        if2.request  = '0;
        if4r.request = '0;
        if4f.request = '0;
        m_ptr        = 0;
        tick("in_rst");
        reset_n = 1'b1;
    endtask

    task automatic apply(int sel, vec_t v, string tag);
        exp_t e;
        if (v.rst_first) do_reset();
        e.gnt   = v.gnt;
        e.valid = |v.gnt;
        e.idx   = v.idx;
        if (sel == 0) begin
            if2.request = v.req[1:0];
            q2.push_back(e);
        end else begin
            if4r.request = v.req;
            qr.push_back(e);
        end
        tick(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t       e;
        logic [3:0] r2;
        logic [3:0] rr;
        logic [3:0] rf;

        fp2_tab[0] = '{1'b0, 4'b0001, 4'b0001, 2'd0};
        fp2_tab[1] = '{1'b0, 4'b0011, 4'b0001, 2'd0};
        fp2_tab[2] = '{1'b0, 4'b0011, 4'b0001, 2'd0};
        fp2_tab[3] = '{1'b0, 4'b0011, 4'b0001, 2'd0};
        fp2_tab[4] = '{1'b0, 4'b0010, 4'b0010, 2'd1};
        fp2_tab[5] = '{1'b0, 4'b0000, 4'b0000, 2'd0};
        fp2_tab[6] = '{1'b0, 4'b0010, 4'b0010, 2'd1};

        rr4_tab[0] = '{1'b1, 4'b1111, 4'b0001, 2'd0};
        rr4_tab[1] = '{1'b0, 4'b1111, 4'b0010, 2'd1};
        rr4_tab[2] = '{1'b0, 4'b1111, 4'b0100, 2'd2};
        rr4_tab[3] = '{1'b0, 4'b1111, 4'b1000, 2'd3};
        rr4_tab[4] = '{1'b0, 4'b1111, 4'b0001, 2'd0};
        rr4_tab[5] = '{1'b1, 4'b1010, 4'b0010, 2'd1};
        rr4_tab[6] = '{1'b0, 4'b1010, 4'b1000, 2'd3};
        rr4_tab[7] = '{1'b0, 4'b1010, 4'b0010, 2'd1};
        rr4_tab[8] = '{1'b0, 4'b0000, 4'b0000, 2'd0};
        rr4_tab[9] = '{1'b0, 4'b1010, 4'b1000, 2'd3};

        reset_n      = 1'b0;
        if2.request  = 2'b11;
        if4r.request = 4'b1111;
        if4f.request = 4'b1111;
        repeat (2) @(posedge clk);
        #1;
        check("rst_fp2", pack({2'b00, if2.grant}, if2.grant_valid, {1'b0, if2.grant_idx}), 8'h00);
        check("rst_rr4", pack(if4r.grant, if4r.grant_valid, if4r.grant_idx), 8'h00);
        check("rst_fp4", pack(if4f.grant, if4f.grant_valid, if4f.grant_idx), 8'h00);
        if2.request  = '0;
        if4r.request = '0;
        if4f.request = '0;
        reset_n      = 1'b1;

        for (int i = 0; i < 7; i++) apply(0, fp2_tab[i], $sformatf("fp2_vec%0d", i));

        // Grant is 2'b10 here; reset falls mid-cycle with request still held.
        #3;
        reset_n = 1'b0;
        #1;
        check("midrst_fp2", pack({2'b00, if2.grant}, if2.grant_valid, {1'b0, if2.grant_idx}), 8'h00);
        @(posedge clk);
        #1;
        check("rst_edge_fp2", pack({2'b00, if2.grant}, if2.grant_valid, {1'b0, if2.grant_idx}), 8'h00);
        reset_n     = 1'b1;
        if2.request = 2'b10;
        q2.push_back('{4'b0010, 1'b1, 2'd1});
        tick("post_rst");
        if2.request = 2'b01;
        q2.push_back('{4'b0001, 1'b1, 2'd0});
        tick("post_rst2");
        if2.request = 2'b00;
        q2.push_back('{4'b0000, 1'b0, 2'd0});
        tick("post_rst3");

        for (int i = 0; i < 10; i++) apply(1, rr4_tab[i], $sformatf("rr4_vec%0d", i));

        do_reset();
        for (int c = 0; c < 1000; c++) begin
            r2 = 4'($urandom);
            rr = 4'($urandom);
            rf = 4'($urandom);
            if (c % 3 == 0) begin
                rr = rr & 4'($urandom);
                rf = rf & 4'($urandom);
            end
            if2.request  = r2[1:0];
            if4r.request = rr;
            if4f.request = rf;
            q2.push_back(fp_model(r2, 2));
            e = rr_model(rr);
            qr.push_back(e);
            qf.push_back(fp_model(rf, 4));
            tick("rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
